// File: rtl/lea_key_schedule_if.sv
// Key-schedule request/read bus between the LEA encryption core (master) and the key expander (slave).
interface lea_key_schedule_if #(
    parameter int KEY_LEN = 128
);
    logic               i_start;
    logic [KEY_LEN-1:0] i_key;
    logic               o_busy;
    logic               o_key_ready;
    logic [4:0]         i_rk_addr;
    logic [191:0]       o_roundkey;

    modport master (
        output i_start, i_key, i_rk_addr,
        input  o_busy, o_key_ready, o_roundkey
    );

    modport slave (
        input  i_start, i_key, i_rk_addr,
        output o_busy, o_key_ready, o_roundkey
    );
endinterface

// File: rtl/lea_key_schedule.sv
// LEA key expansion: one 192-bit round key per cycle into an internal RAM,
// read back by address with one cycle of latency.
module lea_key_schedule #(
    parameter int KEY_LEN = 128
) (
    input logic              clk,
    input logic              rst,
    lea_key_schedule_if.slave bus
);
    localparam int NW = KEY_LEN / 32;
    localparam int NR = (KEY_LEN == 128) ? 24 : (KEY_LEN == 192) ? 28 : 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] DELTA [8] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
        32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
    };
    localparam logic [4:0] SHIFT [6] = '{5'd1, 5'd3, 5'd6, 5'd11, 5'd13, 5'd17};

    logic [1:0]   r_state;
    logic [4:0]   r_rnd;
    logic [31:0]  r_t [8];
    logic [191:0] r_ram [32];
    logic [191:0] r_roundkey;
    logic         r_busy;
    logic         r_ready;

    logic [31:0]  w_t [8];
    logic [191:0] w_rk;
    logic [2:0]   w_didx;
    logic [2:0]   w_base;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // 256-bit keys walk a window of six words around the eight-word state, starting at 6r mod 8
    always_comb begin
        w_t    = r_t;
        w_rk   = '0;
        w_base = 3'(r_rnd) * 3'd6;
        if (KEY_LEN == 128)      w_didx = {1'b0, r_rnd[1:0]};
        else if (KEY_LEN == 192) w_didx = 3'(r_rnd % 5'd6);
        else                     w_didx = r_rnd[2:0];

        if (KEY_LEN == 256) begin
            for (int unsigned k = 0; k < 6; k++) begin
                w_t[w_base + 3'(k)] = rol32(r_t[w_base + 3'(k)]
                                      + rol32(DELTA[w_didx], r_rnd + 5'(k)), SHIFT[3'(k)]);
            end
            for (int unsigned k = 0; k < 6; k++) begin
                w_rk[191 - 32*k -: 32] = w_t[w_base + 3'(k)];
            end
        end else begin
            for (int unsigned k = 0; k < NW; k++) begin
                w_t[3'(k)] = rol32(r_t[3'(k)] + rol32(DELTA[w_didx], r_rnd + 5'(k)), SHIFT[3'(k)]);
            end
            if (KEY_LEN == 128) w_rk = {w_t[0], w_t[1], w_t[2], w_t[1], w_t[3], w_t[1]};
            else                w_rk = {w_t[0], w_t[1], w_t[2], w_t[3], w_t[4], w_t[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rnd      <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_roundkey <= '0;
        end else begin
            r_roundkey <= r_ram[bus.i_rk_addr];
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        for (int unsigned i = 0; i < NW; i++) begin
                            r_t[3'(i)] <= bswap32(bus.i_key[KEY_LEN-1-32*i -: 32]);
                        end
                        r_rnd   <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_t   <= w_t;
                    r_rnd <= r_rnd + 5'd1;
                    if (r_rnd == 5'(NR - 1)) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == S_GEN) r_ram[r_rnd] <= w_rk;
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_key_ready = r_ready;
    assign bus.o_roundkey  = r_roundkey;
endmodule

// File: tb/tb_lea_key_schedule.sv
// Self-checking bench: one expander per key length, random keys checked against a round-by-round reference.
module tb_lea_key_schedule;
    typedef logic [191:0] rk_tab_t [32];

    logic clk;
    int   n_cmp;
    int   n_err;
    int   n_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
        int s;
        logic [63:0] d;
        s = n % 32;
        d = {x, x} << s;
        return d[63:32];
    endfunction

    function automatic rk_tab_t model(input logic [255:0] key, input int kl);
        logic [31:0] delta [8];
        int          s [6];
        logic [31:0] t [8];
        logic [31:0] w;
        int          n, nr, nd, nk, idx;
        rk_tab_t     tab;
        delta = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
                  32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957};
        s  = '{1, 3, 6, 11, 13, 17};
        n  = kl / 32;
        nr = (kl == 128) ? 24 : (kl == 192) ? 28 : 32;
        nd = (kl == 128) ? 4 : (kl == 192) ? 6 : 8;
        nk = (kl == 128) ? 4 : 6;
        for (int i = 0; i < 8; i++) t[i] = '0;
        for (int i = 0; i < 32; i++) tab[i] = '0;
        for (int i = 0; i < n; i++) begin
            w = key[kl-1-32*i -: 32];
            t[i] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        for (int r = 0; r < nr; r++) begin
            for (int k = 0; k < nk; k++) begin
                idx = (kl == 256) ? (6*r + k) % 8 : k;
                t[idx] = m_rol(t[idx] + m_rol(delta[r % nd], r + k), s[k]);
            end
            if (kl == 128)      tab[r] = {t[0], t[1], t[2], t[1], t[3], t[1]};
            else if (kl == 192) tab[r] = {t[0], t[1], t[2], t[3], t[4], t[5]};
            else tab[r] = {t[(6*r)%8], t[(6*r+1)%8], t[(6*r+2)%8],
                           t[(6*r+3)%8], t[(6*r+4)%8], t[(6*r+5)%8]};
        end
        return tab;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_len
        localparam int KL = 128 + 64*g;
        localparam int NR = 24 + 4*g;

        logic rst;
        lea_key_schedule_if #(.KEY_LEN(KL)) bus ();
        lea_key_schedule #(.KEY_LEN(KL)) dut (.clk(clk), .rst(rst), .bus(bus));

        initial begin
            logic [255:0] k;
            rk_tab_t      tab;
            rst            = 1'b1;
            bus.i_start    = 1'b0;
            bus.i_key      = '0;
            bus.i_rk_addr  = '0;
            @(posedge clk);
            @(posedge clk);
            #1;
            check_val($sformatf("k%0d reset busy", KL), 192'(bus.o_busy), 192'd0);
            check_val($sformatf("k%0d reset ready", KL), 192'(bus.o_key_ready), 192'd0);
            check_val($sformatf("k%0d reset rk", KL), bus.o_roundkey, 192'd0);
            rst = 1'b0;

            for (int run = 0; run < 4; run++) begin
                k = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
                if (run == 0) k = {128'd0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};

                if (run == 3) begin
                    bus.i_key   = ~k[KL-1:0];
                    bus.i_start = 1'b1;
                    @(posedge clk);
                    #1 bus.i_start = 1'b0;
                    repeat (10) @(posedge clk);
                    #1 rst = 1'b1;
                    @(posedge clk);
                    #1;
                    check_val($sformatf("k%0d abort busy", KL), 192'(bus.o_busy), 192'd0);
                    check_val($sformatf("k%0d abort ready", KL), 192'(bus.o_key_ready), 192'd0);
                    rst = 1'b0;
                end

                tab = model(k, KL);
                bus.i_key   = k[KL-1:0];
                bus.i_start = 1'b1;
                @(posedge clk);
                #1 bus.i_start = 1'b0;
                for (int c = 0; c <= NR; c++) begin
                    if (c > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (run == 1 && c == 5) begin
                        bus.i_start = 1'b1;
                        bus.i_key   = ~k[KL-1:0];
                    end
                    if (run == 1 && c == 6) bus.i_start = 1'b0;
                    check_val($sformatf("k%0d run%0d busy c%0d", KL, run, c),
                              192'(bus.o_busy), 192'(c < NR));
                    check_val($sformatf("k%0d run%0d ready c%0d", KL, run, c),
                              192'(bus.o_key_ready), 192'(c == NR));
                end

                for (int a = 0; a < NR; a++) begin
                    bus.i_rk_addr = 5'(a);
                    @(posedge clk);
                    #1;
                    check_val($sformatf("k%0d run%0d rk%0d", KL, run, a), bus.o_roundkey, tab[a]);
                    if (KL == 128 && run == 0 && a == 0)
                        check_val("kat rk0", bus.o_roundkey,
                                  192'h003a0fd4_02497010_194f7db1_02497010_090d0883_02497010);
                end
                check_val($sformatf("k%0d run%0d ready hold", KL, run),
                          192'(bus.o_key_ready), 192'd1);
            end
            n_done++;
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;
        for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
        if (n_done < 3) check_val("timeout", 192'(n_done), 192'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
